// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

    // FSM state encoding, shared with the receiver side
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit and flags the
// last cycle of each bit with a one-cycle bit_done pulse.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_done
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

    logic [TICK_W-1:0] tick_q;

    assign bit_done = en && (tick_q == TICK_LAST);

    // Tick counter: wraps to zero at every bit boundary, cleared when a word is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else if (clr) begin
            tick_q <= '0;
        end else if (en) begin
            tick_q <= bit_done ? '0 : tick_q + TICK_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter with valid/ready input handshake.
// Frame: start bit (0), DATA_W data bits LSB first, optional even parity, stop bit (1).
// Define SERIAL_TX_PARITY_EN to include the even-parity bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              C,
    input  logic              R,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              VALID,
    output logic              READY,
    output logic              TX,
    output logic              BUSY
);

    localparam int BIT_CNT_W = $clog2(DATA_W + 1);

    state_t                state_q, state_nx;
    logic [DATA_W-1:0]     shift_q, shift_nx;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_nx;
    logic                  tx_nx;
    logic                  accept;
    logic                  bit_done;
`ifdef SERIAL_TX_PARITY_EN
    logic                  par_q;
`endif

    assign accept = (state_q == IDLE) && VALID;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (C),
        .rst      (R),
        .clr      (accept),
        .en       (state_q != IDLE),
        .bit_done (bit_done)
    );

    // State register
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state, datapath and next line level
    always_comb begin
        state_nx   = state_q;
        shift_nx   = shift_q;
        bit_cnt_nx = bit_cnt_q;
        tx_nx      = LINE_IDLE;
        case (state_q)
            IDLE: begin
                if (VALID) begin
                    state_nx   = START;
                    shift_nx   = D_IN;
                    bit_cnt_nx = '0;
                end
            end
            START: begin
                if (bit_done) state_nx = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_nx   = shift_q >> 1;
                    bit_cnt_nx = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_nx = STOP;
            end
`endif
            STOP: begin
                if (bit_done) state_nx = IDLE;
            end
            // Unused encodings fall back to IDLE
            default: state_nx = IDLE;
        endcase

        // Line level is derived from where the FSM is going so TX can be registered
        case (state_nx)
            START:   tx_nx = START_BIT;
            DATA:    tx_nx = shift_nx[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_nx = par_q;
`endif
            default: tx_nx = LINE_IDLE;
        endcase
    end

    // Shift register, bit counter and latched parity
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_nx;
            bit_cnt_q <= bit_cnt_nx;
`ifdef SERIAL_TX_PARITY_EN
            if (accept) par_q <= ^D_IN;
`endif
        end
    end

    // Registered outputs
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            TX    <= LINE_IDLE;
            READY <= 1'b1;
            BUSY  <= 1'b0;
        end else begin
            TX    <= tx_nx;
            READY <= (state_nx == IDLE);
            BUSY  <= (state_nx != IDLE);
        end
    end

endmodule
